mem_bus_arbiter: RTL and testbench

- Shares the single-port unified memory between two requesters: instruction fetch (I) and the data load/store stage (D).
- Sits between the CPU core and the memory model.
- Serialises requests and gives D priority, with an anti-starvation limit for I.
- Uses a req/ready handshake toward the core and a req/ack handshake toward memory, with variable memory latency.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and the grant-selection function for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;
  typedef enum logic [1:0] {OwnNone, OwnI, OwnD} owner_e;

  localparam logic [3:0] BeFull = 4'hF;

  // D wins unless I has waited through `limit` consecutive D grants.
  function automatic owner_e arb_pick(input logic       i_req,
                                      input logic       d_req,
                                      input logic [3:0] starve_cnt,
                                      input logic [3:0] limit);
    owner_e pick;
    pick = OwnNone;
    if (d_req && (!i_req || (starve_cnt < limit))) begin
      pick = OwnD;
    end else if (i_req) begin
      pick = OwnI;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Serialises instruction-fetch and data requests onto one single-port memory,
// D-priority with a bounded starvation window for I. All outputs registered.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          m_req,
  output logic          m_we,
  output logic [3:0]    m_be,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          busy
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  state_e        state_q;
  owner_e        owner_q;
  logic [3:0]    cnt_q;
  logic          m_req_q, m_we_q, busy_q, i_ready_q, d_ready_q;
  logic [3:0]    m_be_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q, i_rdata_q, d_rdata_q;

  owner_e     grant;
  logic [3:0] cnt_d;

  always_comb begin
    grant = arb_pick(i_req, d_req, cnt_q, Limit);
    cnt_d = cnt_q;
    // Only a D grant that overrides a waiting I advances the starvation count.
    if (grant == OwnD && i_req) begin
      cnt_d = cnt_q + 4'd1;
    end else if (grant != OwnNone) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= OwnNone;
      cnt_q     <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant != OwnNone) begin
            owner_q <= grant;
            cnt_q   <= cnt_d;
            m_req_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StBusy;
            if (grant == OwnI) begin
              m_we_q    <= 1'b0;
              m_be_q    <= BeFull;
              m_addr_q  <= i_addr;
              m_wdata_q <= '0;
            end else begin
              m_we_q    <= d_we;
              m_be_q    <= d_be;
              m_addr_q  <= d_addr;
              m_wdata_q <= d_wdata;
            end
          end
        end
        StBusy: begin
          if (m_ack) begin
            m_req_q <= 1'b0;
            state_q <= StResp;
            if (owner_q == OwnI) begin
              i_rdata_q <= m_rdata;
              i_ready_q <= 1'b1;
            end else begin
              if (!m_we_q) begin
                d_rdata_q <= m_rdata;
              end
              d_ready_q <= 1'b1;
            end
          end
        end
        StResp: begin
          // Requests are deliberately not sampled here.
          owner_q <= OwnNone;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign i_ready = i_ready_q;
  assign d_rdata = d_rdata_q;
  assign d_ready = d_ready_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomised-handshake bench for mem_bus_arbiter (STARVE_LIMIT = 4).
module tb_mem_bus_arbiter;

  logic        clk, rst;
  logic        i_req, i_ready;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ready;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ack;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ready (i_ready),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_be    (d_be),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_be    (m_be),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({m_req, m_we, m_be, i_ready, d_ready, busy} !== 9'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0", {m_req, m_we, m_be, i_ready, d_ready, busy});
    end
    checks++;
    if ({m_addr, m_wdata, i_rdata, d_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h required 0", {m_addr, m_wdata, i_rdata, d_rdata});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    i_req  = 1'b1;
    i_addr = 32'h0000_3000;
    tick();
    checks++;
    if ({m_req, m_we, m_be, m_addr, busy} !== {1'b1, 1'b0, 4'hF, 32'h0000_3000, 1'b1}) begin
      errors++;
      $display("FAIL fetch_mreq: got req=%b we=%b be=%h addr=%h busy=%b required 1 0 f 00003000 1",
               m_req, m_we, m_be, m_addr, busy);
    end
    m_ack   = 1'b1;
    m_rdata = 32'h2008_000A;
    tick();
    m_ack = 1'b0;
    checks++;
    if ({i_ready, d_ready, m_req, i_rdata} !== {3'b100, 32'h2008_000A}) begin
      errors++;
      $display("FAIL fetch_ready: got i_ready=%b d_ready=%b m_req=%b i_rdata=%h required 1 0 0 2008000a",
               i_ready, d_ready, m_req, i_rdata);
    end
    i_req = 1'b0;
    tick();
    checks++;
    if ({i_ready, busy, m_req} !== 3'b000) begin
      errors++;
      $display("FAIL fetch_idle: got i_ready/busy/m_req=%b required 000", {i_ready, busy, m_req});
    end
  endtask

  task automatic test_load();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0020; d_wdata = 32'h0;
    tick();
    checks++;
    if ({m_req, m_we, m_addr} !== {2'b10, 32'h0000_0020}) begin
      errors++;
      $display("FAIL load_mreq: got req=%b we=%b addr=%h required 1 0 00000020", m_req, m_we, m_addr);
    end
    tick();
    checks++;
    if (d_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_early_ready: got %b required 0", d_ready);
    end
    m_ack   = 1'b1;
    m_rdata = 32'h1234_5678;
    tick();
    m_ack = 1'b0;
    checks++;
    if ({d_ready, d_rdata} !== {1'b1, 32'h1234_5678}) begin
      errors++;
      $display("FAIL load_ready: got d_ready=%b d_rdata=%h required 1 12345678", d_ready, d_rdata);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_store_wait_states();
    int pulses;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h0000_0010; d_wdata = 32'hDEAD_BEEF;
    for (int w = 0; w < 4; w++) begin
      tick();
      checks++;
      if ({m_req, m_we, m_be, m_addr, m_wdata, d_ready} !==
          {2'b11, 4'b0011, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0}) begin
        errors++;
        $display("FAIL store_hold[%0d]: got req=%b we=%b be=%b addr=%h wdata=%h d_ready=%b required 1 1 0011 00000010 deadbeef 0",
                 w, m_req, m_we, m_be, m_addr, m_wdata, d_ready);
      end
      if (w == 3) begin
        m_ack   = 1'b1;
        m_rdata = 32'hBAD0_BAD0;
      end
    end
    tick();
    m_ack = 1'b0;
    checks++;
    if ({d_ready, i_ready, d_rdata} !== {2'b10, 32'h1234_5678}) begin
      errors++;
      $display("FAIL store_ready: got d_ready=%b i_ready=%b d_rdata=%h required 1 0 12345678",
               d_ready, i_ready, d_rdata);
    end
    d_req  = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (d_ready) pulses++;
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL store_one_pulse: got extra_pulses=%0d busy=%b required 0 0", pulses, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit exp_d;
    i_addr = 32'h0000_0100; d_addr = 32'h0000_0200; d_we = 1'b0; d_be = 4'hF;
    i_req  = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
        if (m_req === 1'b1) begin
          ok = 1'b1;
          break;
        end
        tick();
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL b2b_timeout[%0d]: got no m_req, required m_req within 20 cycles", k);
        break;
      end
      exp_d = (k % 5) != 4;
      checks++;
      if (m_addr !== (exp_d ? 32'h0000_0200 : 32'h0000_0100)) begin
        errors++;
        $display("FAIL b2b_order[%0d]: got addr=%h required %s grant", k, m_addr, exp_d ? "D" : "I");
      end
      m_ack   = 1'b1;
      m_rdata = 32'h1000_0000 + 32'(k);
      tick();
      m_ack = 1'b0;
      checks++;
      if ({i_ready, d_ready, m_req} !== (exp_d ? 3'b010 : 3'b100)) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got i_ready/d_ready/m_req=%b required %b",
                 k, {i_ready, d_ready, m_req}, exp_d ? 3'b010 : 3'b100);
      end
      tick();
      checks++;
      if ({m_req, busy, i_ready, d_ready} !== 4'b0000) begin
        errors++;
        $display("FAIL b2b_no_regrant[%0d]: got m_req/busy/i_ready/d_ready=%b required 0000",
                 k, {m_req, busy, i_ready, d_ready});
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_late_drop();
    int pulses;
    i_req  = 1'b1;
    i_addr = 32'h0000_0040;
    tick();
    checks++;
    if ({m_req, m_addr} !== {1'b1, 32'h0000_0040}) begin
      errors++;
      $display("FAIL drop_mreq: got req=%b addr=%h required 1 00000040", m_req, m_addr);
    end
    i_req = 1'b0;
    tick();
    tick();
    m_ack   = 1'b1;
    m_rdata = 32'hCAFE_F00D;
    tick();
    m_ack = 1'b0;
    checks++;
    if ({i_ready, i_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
      errors++;
      $display("FAIL drop_ready: got i_ready=%b i_rdata=%h required 1 cafef00d", i_ready, i_rdata);
    end
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (i_ready || m_req || busy) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL drop_idle: got %0d active cycles after completion, required 0", pulses);
    end
  endtask

  task automatic test_reset_mid_busy();
    i_req  = 1'b1;
    i_addr = 32'h0000_0080;
    tick();
    checks++;
    if (m_req !== 1'b1) begin
      errors++;
      $display("FAIL rstbusy_pre: got m_req=%b required 1", m_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({m_req, i_ready, d_ready, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL rstbusy_drop: got m_req/i_ready/d_ready/busy=%b required 0000",
               {m_req, i_ready, d_ready, busy});
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({m_req, m_addr, i_ready} !== {1'b1, 32'h0000_0080, 1'b0}) begin
      errors++;
      $display("FAIL rstbusy_regrant: got req=%b addr=%h i_ready=%b required 1 00000080 0",
               m_req, m_addr, i_ready);
    end
    m_ack   = 1'b1;
    m_rdata = 32'h0BAD_F00D;
    tick();
    m_ack = 1'b0;
    checks++;
    if ({i_ready, i_rdata, d_rdata} !== {1'b1, 32'h0BAD_F00D, 32'h0}) begin
      errors++;
      $display("FAIL rstbusy_ready: got i_ready=%b i_rdata=%h d_rdata=%h required 1 0badf00d 00000000",
               i_ready, i_rdata, d_rdata);
    end
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int          mem_wait;
    bit          rdy_prev;
    logic [31:0] exp_d;
    mem_wait = -1;
    rdy_prev = 1'b0;
    exp_d    = 32'h0;  // d_rdata was cleared by the preceding reset
    for (int cyc = 0; cyc < 1400; cyc++) begin
      tick();
      if (i_ready && d_ready) begin
        checks++;
        errors++;
        $display("FAIL rnd_both_ready[%0d]: got i_ready=1 d_ready=1 required at most one", cyc);
      end
      if (rdy_prev) begin
        checks++;
        if (m_req !== 1'b0) begin
          errors++;
          $display("FAIL rnd_regrant_in_resp[%0d]: got m_req=%b required 0", cyc, m_req);
        end
      end
      rdy_prev = i_ready | d_ready;
      if (i_ready) begin
        checks++;
        if (!i_req || i_rdata !== mem_word(i_addr)) begin
          errors++;
          $display("FAIL rnd_iresp[%0d]: got pending=%b i_rdata=%h required 1 %h",
                   cyc, i_req, i_rdata, mem_word(i_addr));
        end
        i_req = 1'b0;
      end
      if (d_ready) begin
        if (!d_we) exp_d = mem_word(d_addr);
        checks++;
        if (!d_req || d_rdata !== exp_d) begin
          errors++;
          $display("FAIL rnd_dresp[%0d]: got pending=%b d_rdata=%h required 1 %h",
                   cyc, d_req, d_rdata, exp_d);
        end
        d_req = 1'b0;
      end
      if (m_ack) begin
        m_ack = 1'b0;
      end else if (m_req) begin
        if (mem_wait < 0) mem_wait = int'($urandom_range(0, 7));
        if (mem_wait == 0) begin
          m_ack    = 1'b1;
          m_rdata  = mem_word(m_addr);
          mem_wait = -1;
        end else begin
          mem_wait--;
        end
      end
      if (cyc < 1000) begin
        if (!i_req && !i_ready && $urandom_range(0, 1) == 1) begin
          i_req  = 1'b1;
          i_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_req && !d_ready && $urandom_range(0, 1) == 1) begin
          d_req   = 1'b1;
          d_we    = 1'($urandom_range(0, 1));
          d_be    = 4'($urandom_range(0, 15));
          d_addr  = $urandom;
          d_wdata = $urandom;
        end
      end else if (!i_req && !d_req && !busy && !m_ack) begin
        break;
      end
    end
    checks++;
    if ({busy, m_req, i_req, d_req} !== 4'b0000) begin
      errors++;
      $display("FAIL rnd_drain: got busy/m_req/i_pend/d_pend=%b required 0000",
               {busy, m_req, i_req, d_req});
    end
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_be = '0;
    d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack = 1'b0;
    test_reset();
    test_single_fetch();
    test_load();
    test_store_wait_states();
    test_back_to_back();
    test_late_drop();
    test_reset_mid_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
